// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares a single barrier gate between the entry and exit lanes of a parking
// lot. Entry requests are qualified by the password result and by the lot not
// being full; exit requests are qualified by the lot not being empty. When both
// lanes qualify in the same cycle, the lane not served last wins. The gate is
// then sequenced through OPEN (wait for the car to clear the loop sensor, or
// time out) and CLOSING (hold the gate shut before the next grant). The block
// also keeps the occupancy count.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   entry_req    car present at entry sensor (level)
//   entry_auth   password accepted for the waiting entry car (level)
//   exit_req     car present at exit sensor (level)
//   car_passed   one-cycle pulse, car has cleared the gate
//   gate_open    gate actuator command, 1 = open
//   entry_grant  one-cycle pulse, entry lane granted
//   exit_grant   one-cycle pulse, exit lane granted
//   occupancy    cars currently inside
//   full         occupancy == CAPACITY
//   empty        occupancy == 0
//   fault        one-cycle pulse on open timeout
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int OPEN_TIMEOUT = 20,
    parameter int CLOSE_HOLD   = 3,
    parameter int TMR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             entry_auth,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             fault
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSING = 2'd2
    } state_t;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] OCC_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] OCC_ONE_C  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO_C = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE_C  = TMR_W'(1);
    localparam logic [TMR_W-1:0] OPEN_LAST_C  = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CLOSE_LAST_C = TMR_W'(CLOSE_HOLD - 1);

    // Saturating occupancy step. Qualification already keeps the count in
    // range; the guard stops a stray pass from wrapping the counter.
    function automatic logic [CNT_W-1:0] occ_step(
        input logic [CNT_W-1:0] occ,
        input dir_t             dir
    );
        logic [CNT_W-1:0] res;
        res = occ;
        if (dir == DIR_ENTRY) begin
            if (occ < CAP_C) begin
                res = occ + OCC_ONE_C;
            end else begin
                res = occ;
            end
        end else begin
            if (occ > OCC_ZERO_C) begin
                res = occ - OCC_ONE_C;
            end else begin
                res = occ;
            end
        end
        return res;
    endfunction

    state_t           state_r, state_s;
    dir_t             dir_r, dir_s;
    dir_t             last_served_r, last_served_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [CNT_W-1:0] occ_r, occ_s;
    logic             full_r, full_s;
    logic             empty_r, empty_s;
    logic             gate_open_r, gate_open_s;
    logic             entry_grant_r, entry_grant_s;
    logic             exit_grant_r, exit_grant_s;
    logic             fault_r, fault_s;

    logic             entry_q_s;
    logic             exit_q_s;

    assign entry_q_s = entry_req & entry_auth & ~full_r;
    assign exit_q_s  = exit_req & ~empty_r;

    // Next-state, counter and output-pulse logic for the gate sequencer.
    always_comb begin
        state_s       = state_r;
        dir_s         = dir_r;
        last_served_s = last_served_r;
        timer_s       = timer_r;
        occ_s         = occ_r;
        gate_open_s   = gate_open_r;
        entry_grant_s = 1'b0;
        exit_grant_s  = 1'b0;
        fault_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Entry wins when it is alone, or on a tie when exit was
                // served last.
                if (entry_q_s && (!exit_q_s || (last_served_r == DIR_EXIT))) begin
                    state_s       = ST_OPEN;
                    dir_s         = DIR_ENTRY;
                    last_served_s = DIR_ENTRY;
                    timer_s       = TMR_ZERO_C;
                    gate_open_s   = 1'b1;
                    entry_grant_s = 1'b1;
                end else if (exit_q_s) begin
                    state_s       = ST_OPEN;
                    dir_s         = DIR_EXIT;
                    last_served_s = DIR_EXIT;
                    timer_s       = TMR_ZERO_C;
                    gate_open_s   = 1'b1;
                    exit_grant_s  = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                    gate_open_s = 1'b0;
                end
            end

            ST_OPEN: begin
                // A pass on the last open cycle still counts as a pass.
                if (car_passed) begin
                    occ_s       = occ_step(occ_r, dir_r);
                    state_s     = ST_CLOSING;
                    timer_s     = TMR_ZERO_C;
                    gate_open_s = 1'b0;
                end else if (timer_r == OPEN_LAST_C) begin
                    state_s     = ST_CLOSING;
                    timer_s     = TMR_ZERO_C;
                    gate_open_s = 1'b0;
                    fault_s     = 1'b1;
                end else begin
                    timer_s     = timer_r + TMR_ONE_C;
                    gate_open_s = 1'b1;
                end
            end

            ST_CLOSING: begin
                gate_open_s = 1'b0;
                if (timer_r == CLOSE_LAST_C) begin
                    state_s = ST_IDLE;
                    timer_s = TMR_ZERO_C;
                end else begin
                    timer_s = timer_r + TMR_ONE_C;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                timer_s     = TMR_ZERO_C;
                gate_open_s = 1'b0;
            end
        endcase

        // Flags track the value the counter is about to take.
        full_s  = (occ_s == CAP_C);
        empty_s = (occ_s == OCC_ZERO_C);
    end

    // State, counter and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            dir_r         <= DIR_ENTRY;
            last_served_r <= DIR_EXIT;
            timer_r       <= TMR_ZERO_C;
            occ_r         <= OCC_ZERO_C;
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
            gate_open_r   <= 1'b0;
            entry_grant_r <= 1'b0;
            exit_grant_r  <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            dir_r         <= dir_s;
            last_served_r <= last_served_s;
            timer_r       <= timer_s;
            occ_r         <= occ_s;
            full_r        <= full_s;
            empty_r       <= empty_s;
            gate_open_r   <= gate_open_s;
            entry_grant_r <= entry_grant_s;
            exit_grant_r  <= exit_grant_s;
            fault_r       <= fault_s;
        end
    end

    assign gate_open   = gate_open_r;
    assign entry_grant = entry_grant_r;
    assign exit_grant  = exit_grant_r;
    assign occupancy   = occ_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for parking_gate_arbiter. Stimulus pushes the events it expects the
// gate to produce (grant, fault, gate closing) into a queue; a monitor samples
// the outputs on the falling clock edge and pops/compares on every event.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

    localparam int CAPACITY   = 8;
    localparam int CNT_W      = 4;
    localparam int CLOSE_HOLD = 3;

    localparam int K_EGRANT = 0;
    localparam int K_XGRANT = 1;
    localparam int K_FAULT  = 2;
    localparam int K_CLOSE  = 3;

    typedef struct {
        int kind;
        int occ;
        bit full;
        bit empty;
        bit gate;
        int len;   // grant: cycles since last gate fall; close: open cycles; 0 = don't care
    } ev_t;

    logic             clk;
    logic             rst;
    logic             entry_req;
    logic             entry_auth;
    logic             exit_req;
    logic             car_passed;
    logic             gate_open;
    logic             entry_grant;
    logic             exit_grant;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             fault;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    parking_gate_arbiter #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .OPEN_TIMEOUT(20),
        .CLOSE_HOLD(CLOSE_HOLD), .TMR_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .entry_req(entry_req), .entry_auth(entry_auth), .exit_req(exit_req),
        .car_passed(car_passed), .gate_open(gate_open),
        .entry_grant(entry_grant), .exit_grant(exit_grant),
        .occupancy(occupancy), .full(full), .empty(empty), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic push(input int kind, input int occ, input int len);
        ev_t e;
        e.kind  = kind;
        e.occ   = occ;
        e.full  = (occ == CAPACITY);
        e.empty = (occ == 0);
        e.gate  = (kind == K_EGRANT) || (kind == K_XGRANT);
        e.len   = len;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d occ=%0d len=%0d, required no event",
                     kind, occupancy, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.occ != int'(occupancy) || e.full != full ||
                e.empty != empty || e.gate != gate_open || (e.len != 0 && e.len != len)) begin
                errors++;
                $display("FAIL event: got kind=%0d occ=%0d full=%0d empty=%0d gate=%0d len=%0d, required kind=%0d occ=%0d full=%0d empty=%0d gate=%0d len=%0d",
                         kind, occupancy, full, empty, gate_open, len,
                         e.kind, e.occ, e.full, e.empty, e.gate, e.len);
            end
        end
    endtask

    // Monitor: detects grant/fault pulses and gate falling edges.
    initial begin
        bit prev_gate;
        int gap;
        int open_cnt;
        prev_gate = 1'b0;
        gap       = 255;
        open_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_gate = 1'b0;
                gap       = 255;
                open_cnt  = 0;
            end else begin
                if (prev_gate && !gate_open) gap = 0;
                else if (gap < 255) gap++;
                if (gate_open && !prev_gate) open_cnt = 1;
                else if (gate_open) open_cnt++;
                if (entry_grant) check_ev(K_EGRANT, gap);
                if (exit_grant)  check_ev(K_XGRANT, gap);
                if (fault)       check_ev(K_FAULT, 0);
                if (prev_gate && !gate_open) check_ev(K_CLOSE, open_cnt);
                prev_gate = gate_open;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_level(input bit lvl, input string name);
        int i;
        checks++;
        for (i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (gate_open == lvl) break;
        end
        if (i == 60) begin
            errors++;
            $display("FAIL %s: gate_open never reached %0d within 60 cycles", name, lvl);
        end
    endtask

    task automatic car_pulse(input int delay);
        tick(delay);
        car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
    endtask

    task automatic settle();
        tick(CLOSE_HOLD + 3);
    endtask

    // One full transaction for a single lane, pass after 'delay' open cycles.
    task automatic txn(input bit is_exit, input int occ_before, input int delay);
        int occ_after;
        occ_after = is_exit ? occ_before - 1 : occ_before + 1;
        push(is_exit ? K_XGRANT : K_EGRANT, occ_before, 0);
        push(K_CLOSE, occ_after, delay + 1);
        if (is_exit) exit_req = 1'b1;
        else begin entry_req = 1'b1; entry_auth = 1'b1; end
        wait_level(1'b1, "txn_open");
        exit_req   = 1'b0;
        entry_req  = 1'b0;
        entry_auth = 1'b0;
        car_pulse(delay);
        settle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b0;
        entry_req  = 1'b0;
        entry_auth = 1'b0;
        exit_req   = 1'b0;
        car_passed = 1'b0;

        // Reset state
        tick(2);
        chk("rst_gate_open", gate_open, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_grants", entry_grant | exit_grant, 0);
        chk("rst_fault", fault, 0);
        rst = 1'b1;
        tick(2);

        // Authorised entry, pass on first open cycle (auth dropped after grant)
        txn(1'b0, 0, 0);

        // Unauthorised entry: never granted
        entry_req = 1'b1;
        tick(30);
        chk("no_auth_gate", gate_open, 0);
        entry_req = 1'b0;
        tick(1);

        // Tie with occupancy 1: last served entry, so exit first; then exit is
        // disqualified (empty) and the held entry follows CLOSE_HOLD+1 later.
        push(K_XGRANT, 1, 0);
        push(K_CLOSE, 0, 1);
        push(K_EGRANT, 0, CLOSE_HOLD + 1);
        push(K_CLOSE, 1, 1);
        entry_req = 1'b1; entry_auth = 1'b1; exit_req = 1'b1;
        wait_level(1'b1, "tie_open1");
        car_pulse(0);
        wait_level(1'b1, "tie_open2");
        entry_req = 1'b0; entry_auth = 1'b0; exit_req = 1'b0;
        car_pulse(0);
        settle();

        // Timeout without pass: fault with gate fall, occupancy unchanged
        push(K_EGRANT, 1, 0);
        push(K_FAULT, 1, 0);
        push(K_CLOSE, 1, 20);
        entry_req = 1'b1; entry_auth = 1'b1;
        wait_level(1'b1, "to_open");
        entry_req = 1'b0; entry_auth = 1'b0;
        wait_level(1'b0, "to_close");
        settle();

        // Pass on the timeout cycle counts as a pass
        txn(1'b0, 1, 19);

        // Fill the lot
        for (int k = 2; k < CAPACITY; k++) txn(1'b0, k, 1);
        chk("cap_full", full, 1);
        chk("cap_occ", occupancy, CAPACITY);

        // 9th entry refused while full; exit then unlocks entry (tie, exit last)
        entry_req = 1'b1; entry_auth = 1'b1;
        tick(30);
        chk("full_refused_gate", gate_open, 0);
        push(K_XGRANT, 8, 0);
        push(K_CLOSE, 7, 1);
        push(K_EGRANT, 7, CLOSE_HOLD + 1);
        push(K_CLOSE, 8, 3);
        exit_req = 1'b1;
        wait_level(1'b1, "cap_exit_open");
        car_pulse(0);
        wait_level(1'b1, "cap_entry_open");
        entry_req = 1'b0; entry_auth = 1'b0; exit_req = 1'b0;
        car_pulse(2);
        settle();

        // Down to 5 cars
        txn(1'b1, 8, 0);
        txn(1'b1, 7, 4);
        txn(1'b1, 6, 0);
        chk("occ_five", occupancy, 5);

        // Reset while OPEN
        push(K_EGRANT, 5, 0);
        entry_req = 1'b1; entry_auth = 1'b1;
        wait_level(1'b1, "mid_open");
        entry_req = 1'b0; entry_auth = 1'b0;
        tick(3);
        rst = 1'b0;
        #1;
        chk("mid_rst_gate", gate_open, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_fault", fault, 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // After release: requests from both lanes with empty lot -> entry
        push(K_EGRANT, 0, 0);
        push(K_CLOSE, 1, 1);
        entry_req = 1'b1; entry_auth = 1'b1; exit_req = 1'b1;
        wait_level(1'b1, "post_rst_open");
        entry_req = 1'b0; entry_auth = 1'b0; exit_req = 1'b0;
        car_pulse(0);
        settle();

        // True tie after entry served -> exit
        push(K_XGRANT, 1, 0);
        push(K_CLOSE, 0, 1);
        entry_req = 1'b1; entry_auth = 1'b1; exit_req = 1'b1;
        wait_level(1'b1, "post_rst_tie");
        entry_req = 1'b0; entry_auth = 1'b0; exit_req = 1'b0;
        car_pulse(0);
        settle();

        tick(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Shares one barrier gate between the entry lane and the exit lane of the smart parking lot.
- Qualifies requests using the password-authorisation result and the current occupancy, then arbitrates ties round-robin.
- Sequences the gate through open, wait-for-pass and close-guard phases, and maintains the occupancy counter.
- Sits between the lane sensors/password checker and the gate actuator and status LEDs.

Parameters:
CAPACITY, 8, number of parking slots; occupancy never exceeds this value
CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY
OPEN_TIMEOUT, 20, cycles the gate stays open waiting for car_passed before aborting
CLOSE_HOLD, 3, cycles the gate is held closed after any open phase before a new grant
TMR_W, 8, phase timer width; must hold max(OPEN_TIMEOUT, CLOSE_HOLD)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
entry_req  input  1  level, car present at entry sensor
entry_auth  input  1  level, password accepted for the waiting entry car
exit_req  input  1  level, car present at exit sensor
car_passed  input  1  one-cycle pulse from gate loop sensor, car has cleared the gate
gate_open  output  1  gate actuator command, 1 = open
entry_grant  output  1  one-cycle pulse, entry lane granted
exit_grant  output  1  one-cycle pulse, exit lane granted
occupancy  output  CNT_W  cars currently inside
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0
fault  output  1  one-cycle pulse on open timeout

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low: rst=0 immediately forces gate_open=0, grants=0, fault=0, occupancy=0, empty=1, full=0, state=IDLE, timer=0, last_served=EXIT.
- Qualified requests:
  - entry_q = entry_req & entry_auth & !full
  - exit_q = exit_req & !empty
- States: IDLE, OPEN, CLOSING. A dir register records the lane being served (ENTRY or EXIT).
- IDLE:
  - Only entry_q at edge N → state OPEN, dir=ENTRY, timer=0. From cycle N+1, entry_grant=1 for exactly one cycle and gate_open=1.
  - Only exit_q → same sequence with exit_grant.
  - Both qualified → grant the lane opposite to last_served. The first tie after reset therefore goes to ENTRY.
  - last_served updates to the granted lane on every grant.
  - car_passed is ignored in IDLE.
- OPEN:
  - gate_open=1 and the timer increments every cycle.
  - car_passed=1 → occupancy +1 if dir=ENTRY, −1 if dir=EXIT. Then state CLOSING, timer=0, and gate_open=0 from the next cycle.
  - Timer reaches OPEN_TIMEOUT−1 without car_passed → state CLOSING, occupancy unchanged, fault=1 for one cycle concurrent with gate_open falling.
  - car_passed on the timeout cycle counts as a pass, not a fault.
  - New requests are not latched while in OPEN; lanes keep their levels asserted.
- CLOSING:
  - gate_open=0 for exactly CLOSE_HOLD cycles, then IDLE.
  - car_passed is ignored.
  - Requests are re-evaluated in IDLE, so the earliest regrant is CLOSE_HOLD+1 cycles after gate_open falls.
- Arithmetic:
  - occupancy saturates at CAPACITY and at 0. Qualification already prevents overflow; the saturation is a defensive guard.
  - full and empty are registered, updated in the same cycle as occupancy.
- entry_auth dropping after a grant does not cancel the open phase.
- Reset asserted mid-OPEN: gate closes immediately, occupancy clears to 0, and no fault is raised.

Test Plan:
- Reset: hold rst=0 for 2 cycles → gate_open=0, occupancy=0, empty=1, full=0, no grant or fault pulses.
- Authorised entry: entry_req=1, entry_auth=1 → entry_grant pulses 1 cycle and gate_open=1 the next cycle. Pulse car_passed → occupancy=1, empty=0, gate_open=0 for 3 cycles, then IDLE. Repeat with entry_auth=0 → no grant ever.
- Tie round-robin: after the entry above (occupancy=1), assert entry_req, entry_auth and exit_req together → exit_grant first. After pass, occupancy=0 and exit is disqualified (empty), so entry is granted next.
- Timeout: grant entry and withhold car_passed → gate_open falls after 20 open cycles, fault=1 for 1 cycle, occupancy unchanged. Repeat with car_passed on cycle 20 → counted, no fault.
- Capacity: perform 8 entries → occupancy=8, full=1. A 9th entry_req+auth gets no grant. One exit → occupancy=7, full=0, and the entry is then granted.
- Mid-operation reset: rst=0 while OPEN with occupancy=5 → gate_open=0 asynchronously, occupancy=0, and the first tie after release goes to ENTRY.
